// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU sequencer: opcodes, instruction phases,
// sequencer FSM states and the bundle of datapath control levels.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] PH_0 = 3'd0;
  localparam logic [2:0] PH_1 = 3'd1;
  localparam logic [2:0] PH_2 = 3'd2;
  localparam logic [2:0] PH_3 = 3'd3;
  localparam logic [2:0] PH_4 = 3'd4;
  localparam logic [2:0] PH_5 = 3'd5;
  localparam logic [2:0] PH_6 = 3'd6;
  localparam logic [2:0] PH_7 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } ctrl_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

  // Phases that wait on the memory bus: instruction fetch, operand read or store.
  function automatic logic is_mem_phase(input logic [2:0] ph, input logic [2:0] op);
    return (ph == PH_2) || ((ph == PH_7) && (is_aluop(op) || (op == OP_STO)));
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational phase/opcode decode into datapath control levels. No gating here:
// the sequencer qualifies these with its active and advance conditions.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [2:0] phase,
  input  logic [2:0] opcode,
  input  logic       ac_zero,
  output ctrl_t      ctrl,
  output logic       hlt_cond
);

  logic alu_op;
  logic sto_op;
  logic jmp_op;
  logic skz_op;

  assign alu_op = is_aluop(opcode);
  assign sto_op = (opcode == OP_STO);
  assign jmp_op = (opcode == OP_JMP);
  assign skz_op = (opcode == OP_SKZ);

  always_comb begin
    ctrl     = '0;
    hlt_cond = 1'b0;
    case (phase)
      PH_0: ctrl.sel = 1'b1;
      PH_1: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      PH_2, PH_3: begin
        ctrl.sel   = 1'b1;
        ctrl.rd    = 1'b1;
        ctrl.ld_ir = 1'b1;
      end
      PH_4: begin
        ctrl.inc_pc = 1'b1;
        hlt_cond    = (opcode == OP_HLT);
      end
      PH_5: ctrl.rd = alu_op;
      PH_6: begin
        ctrl.rd     = alu_op;
        ctrl.inc_pc = skz_op & ac_zero;
        ctrl.ld_pc  = jmp_op;
        ctrl.data_e = sto_op;
      end
      PH_7: begin
        ctrl.rd     = alu_op;
        ctrl.ld_ac  = alu_op;
        ctrl.ld_pc  = jmp_op;
        ctrl.data_e = sto_op;
        ctrl.wr     = sto_op;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Run/step/halt sequencer for the accumulator CPU: phase counter, memory stall, strobe gating.
// Optional build macro MEM_TIMEOUT_EN adds a wait-state watchdog driving a sticky bus_err.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       ac_zero,
  input  logic       mem_ready,
  input  logic       run,
  input  logic       step,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic       halt,
  output logic       instr_done,
  output logic       bus_err
);

  if (2 ** TO_W <= TIMEOUT_CYCLES) begin : g_cfg_check
    $error("cpu_sequencer: TO_W too narrow to count TIMEOUT_CYCLES");
  end

  seq_state_t state;
  logic [2:0] phase_q;
  logic       halt_q;
  logic       run_q;

  ctrl_t      lvl;
  logic       hlt_cond;
  logic       active;
  logic       stall;
  logic       adv;
  logic       to_fire;

  cpu_ctrl_decode u_decode (
    .phase    (phase_q),
    .opcode   (opcode),
    .ac_zero  (ac_zero),
    .ctrl     (lvl),
    .hlt_cond (hlt_cond)
  );

  assign active = (state == ST_RUN) || (state == ST_STEP);
  assign stall  = active && is_mem_phase(phase_q, opcode) && !mem_ready;
  assign adv    = active && !stall;

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            bus_err_q;

  // Fires on the stall cycle that brings the count up to TIMEOUT_CYCLES.
  assign to_fire = stall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else if (to_fire) begin
      to_cnt    <= '0;
      bus_err_q <= 1'b1;
    end else if (stall) begin
      to_cnt    <= to_cnt + TO_W'(1);
    end else begin
      to_cnt    <= '0;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign to_fire = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      phase_q <= PH_0;
      halt_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q <= run;
      case (state)
        ST_IDLE: begin
          phase_q <= PH_0;
          if (run) begin
            state <= ST_RUN;
          end else if (step) begin
            state <= ST_STEP;
          end
        end
        ST_RUN, ST_STEP: begin
          if (to_fire) begin
            state   <= ST_HALTED;
            phase_q <= PH_0;
            halt_q  <= 1'b1;
          end else if (adv) begin
            if (hlt_cond) begin
              state   <= ST_HALTED;
              phase_q <= PH_0;
              halt_q  <= 1'b1;
            end else begin
              phase_q <= phase_q + 3'd1;
              // An instruction in flight always finishes before dropping back to IDLE.
              if ((phase_q == PH_7) && ((state == ST_STEP) || !run)) begin
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_HALTED: begin
          phase_q <= PH_0;
          if (run && !run_q) begin
            state  <= ST_RUN;
            halt_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          phase_q <= PH_0;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign phase      = phase_q;
  assign halt       = halt_q;

  assign sel        = active & lvl.sel;
  assign rd         = active & lvl.rd;
  assign data_e     = active & lvl.data_e;

  // Load/increment/write strobes fire only on the advancing cycle of their phase.
  assign ld_ir      = adv & lvl.ld_ir;
  assign inc_pc     = adv & lvl.inc_pc;
  assign ld_pc      = adv & lvl.ld_pc;
  assign ld_ac      = adv & lvl.ld_ac;
  assign wr         = adv & lvl.wr;
  assign instr_done = adv & (phase_q == PH_7);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a per-cycle behavioural reference model.
module tb_cpu_sequencer;

  localparam int TO_CYC = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [2:0] opcode    = 3'd0;
  logic       ac_zero   = 1'b0;
  logic       mem_ready = 1'b1;
  logic       run       = 1'b0;
  logic       step      = 1'b0;

  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr;
  logic       halt, instr_done, bus_err;

  int total = 0;
  int bad   = 0;

  int m_mode = M_IDLE;
  int m_ph   = 0;
  bit m_prev = 1'b0;
  bit m_err  = 1'b0;
`ifdef MEM_TIMEOUT_EN
  int m_to   = 0;
`endif

  int n_ld_ir, n_inc, n_ld_pc, n_ld_ac, n_wr, n_done;

  cpu_sequencer #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .ac_zero    (ac_zero),
    .mem_ready  (mem_ready),
    .run        (run),
    .step       (step),
    .phase      (phase),
    .sel        (sel),
    .rd         (rd),
    .ld_ir      (ld_ir),
    .inc_pc     (inc_pc),
    .ld_pc      (ld_pc),
    .data_e     (data_e),
    .ld_ac      (ld_ac),
    .wr         (wr),
    .halt       (halt),
    .instr_done (instr_done),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  function automatic bit is_alu(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
  endfunction

  // Per-phase control levels {sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr}.
  function automatic logic [7:0] levels(input int ph, input logic [2:0] op, input logic acz);
    bit alu, sto, jmp, skz;
    alu = is_alu(op);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    skz = (op == 3'd1);
    case (ph)
      0:       return 8'b1000_0000;
      1:       return 8'b1100_0000;
      2, 3:    return 8'b1110_0000;
      4:       return 8'b0001_0000;
      5:       return {1'b0, alu, 6'b0};
      6:       return {1'b0, alu, 1'b0, skz & acz, jmp, sto, 2'b00};
      default: return {1'b0, alu, 2'b00, jmp, sto, alu, sto};
    endcase
  endfunction

  function automatic bit active_now();
    return (m_mode == M_RUN) || (m_mode == M_STEP);
  endfunction

  function automatic bit waits_now();
    return active_now() && !mem_ready &&
           ((m_ph == 2) || ((m_ph == 7) && (is_alu(opcode) || (opcode == 3'd6))));
  endfunction

  function automatic logic [13:0] expected();
    logic [7:0] lv, c;
    bit mv;
    mv = active_now() && !waits_now();
    lv = levels(m_ph, opcode, ac_zero);
    c  = 8'h00;
    if (active_now()) c = lv & 8'b1100_0100;
    if (mv)           c = c | (lv & 8'b0011_1011);
    return {3'(m_ph), c, (m_mode == M_HALT), (mv && (m_ph == 7)), m_err};
  endfunction

  task automatic model_step();
    bit w, mv;
    w  = waits_now();
    mv = active_now() && !w;
    case (m_mode)
      M_IDLE: begin
        if (run) m_mode = M_RUN;
        else if (step) m_mode = M_STEP;
      end
      M_HALT: begin
        if (run && !m_prev) m_mode = M_RUN;
      end
      default: begin
`ifdef MEM_TIMEOUT_EN
        if (w) begin
          m_to++;
          if (m_to == TO_CYC) begin
            m_err  = 1'b1;
            m_mode = M_HALT;
            m_ph   = 0;
            m_to   = 0;
          end
        end else begin
          m_to = 0;
        end
`endif
        if (mv) begin
          if ((m_ph == 4) && (opcode == 3'd0)) begin
            m_mode = M_HALT;
            m_ph   = 0;
          end else begin
            if ((m_ph == 7) && ((m_mode == M_STEP) || !run)) m_mode = M_IDLE;
            m_ph = (m_ph + 1) % 8;
          end
        end
      end
    endcase
    m_prev = run;
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = M_IDLE;
        m_ph   = 0;
        m_prev = 1'b0;
        m_err  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        m_to   = 0;
`endif
      end else begin
        model_step();
      end
    end
  end

  initial begin : compare_proc
    logic [13:0] got, want;
    forever begin
      @(negedge clk);
      got  = {phase, sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, instr_done, bus_err};
      want = expected();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL cycle_model t=%0t got=%b want=%b", $time, got, want);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic clear_tally();
    n_ld_ir = 0; n_inc = 0; n_ld_pc = 0; n_ld_ac = 0; n_wr = 0; n_done = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    n_ld_ir += int'(ld_ir);
    n_inc   += int'(inc_pc);
    n_ld_pc += int'(ld_pc);
    n_ld_ac += int'(ld_ac);
    n_wr    += int'(wr);
    n_done  += int'(instr_done);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // One full instruction launched by a run pulse, no wait states, back to IDLE.
  task automatic run_one(input logic [2:0] op, input string tag);
    opcode = op;
    run    = 1'b1;
    clear_tally();
    sample();
    check({tag, "_idle_sel"}, int'(sel), 0);
    nxt();
    run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      check({tag, "_phase"}, int'(phase), i);
      nxt();
    end
    sample();
    check({tag, "_end_idle"}, int'({phase, sel}), 0);
    nxt();
  endtask

  initial begin : main
    clear_tally();
    nxt();
    nxt();
    sample();
    check("reset_outputs",
          int'({phase, sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, instr_done, bus_err}), 0);
    nxt();
    rst_n = 1'b1;

    // ADD, free-run for one instruction
    run_one(3'd2, "add");
    check("add_ld_ac_cnt", n_ld_ac, 1);
    check("add_done_cnt", n_done, 1);
    check("add_ld_ir_cnt", n_ld_ir, 2);

    // STO with three wait states at ph7
    opcode = 3'd6;
    run    = 1'b1;
    clear_tally();
    sample();
    nxt();
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample();
      nxt();
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("sto_stall_phase", int'(phase), 7);
      check("sto_stall_data_e", int'(data_e), 1);
      check("sto_stall_wr", int'(wr), 0);
      nxt();
    end
    mem_ready = 1'b1;
    sample();
    check("sto_wr_on_ready", int'(wr), 1);
    check("sto_done_on_ready", int'(instr_done), 1);
    nxt();
    sample();
    check("sto_end_idle", int'({phase, sel}), 0);
    nxt();
    check("sto_wr_cnt", n_wr, 1);

    // SKZ with and without a zero accumulator
    ac_zero = 1'b1;
    run_one(3'd1, "skz1");
    check("skz_zero_inc_cnt", n_inc, 2);
    ac_zero = 1'b0;
    run_one(3'd1, "skz0");
    check("skz_nonzero_inc_cnt", n_inc, 1);

    // run and step together: run wins, so the sequencer keeps going past ph7
    opcode = 3'd2;
    run    = 1'b1;
    step   = 1'b1;
    sample();
    nxt();
    step = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      nxt();
    end
    sample();
    check("prio_rerun_phase", int'(phase), 0);
    check("prio_rerun_sel", int'(sel), 1);
    nxt();
    run = 1'b0;
    for (int i = 1; i < 8; i++) begin
      sample();
      nxt();
    end
    sample();
    check("prio_end_idle", int'({phase, sel}), 0);
    nxt();

    // HLT halts after ph4, ignores step, resumes on a run edge
    opcode = 3'd0;
    run    = 1'b1;
    sample();
    nxt();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      nxt();
    end
    clear_tally();
    sample();
    check("hlt_halt", int'(halt), 1);
    check("hlt_phase", int'(phase), 0);
    nxt();
    step = 1'b1;
    sample();
    nxt();
    step = 1'b0;
    sample();
    check("hlt_step_ignored", int'(halt), 1);
    check("hlt_no_strobes", n_ld_ir + n_inc + n_ld_pc + n_ld_ac + n_wr + n_done, 0);
    nxt();
    run    = 1'b1;
    opcode = 3'd2;
    sample();
    check("hlt_still_halted", int'(halt), 1);
    nxt();
    run = 1'b0;
    sample();
    check("resume_halt", int'(halt), 0);
    check("resume_phase_sel", int'({phase, sel}), 1);
    nxt();
    for (int i = 1; i < 8; i++) begin
      sample();
      nxt();
    end
    sample();
    nxt();

    // Single step of JMP
    opcode = 3'd7;
    step   = 1'b1;
    clear_tally();
    sample();
    nxt();
    step = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i >= 6) check("jmp_ld_pc_level", int'(ld_pc), 1);
      nxt();
    end
    sample();
    check("step_end_idle", int'({phase, sel}), 0);
    nxt();
    check("jmp_ld_pc_cnt", n_ld_pc, 2);
    check("jmp_done_cnt", n_done, 1);

    // Second step, reset dropped asynchronously during ph5
    step = 1'b1;
    sample();
    nxt();
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      nxt();
    end
    #1;
    check("step2_ph5", int'(phase), 5);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({phase, sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, instr_done, bus_err}), 0);
    nxt();
    nxt();
    rst_n = 1'b1;
    sample();
    check("post_reset_idle", int'({phase, halt}), 0);
    nxt();

`ifdef MEM_TIMEOUT_EN
    // Fetch never completes: watchdog halts with bus_err
    opcode    = 3'd2;
    mem_ready = 1'b0;
    run       = 1'b1;
    sample();
    nxt();
    run = 1'b0;
    clear_tally();
    sample();
    nxt();
    sample();
    nxt();
    for (int i = 0; i < TO_CYC; i++) begin
      sample();
      check("to_stall_phase", int'(phase), 2);
      check("to_err_low", int'(bus_err), 0);
      nxt();
    end
    sample();
    check("to_bus_err", int'(bus_err), 1);
    check("to_halt", int'(halt), 1);
    check("to_phase", int'(phase), 0);
    check("to_no_ld_ir", n_ld_ir, 0);
    nxt();
    mem_ready = 1'b1;
    sample();
    check("to_err_sticky", int'(bus_err), 1);
    nxt();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
